// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared constants for the sequential shift-add multiplier
package multiplier_pkg;
    localparam int MUL_W     = 32;
    localparam int MUL_STEPS = 32;
    localparam int MUL_SW    = 6;

    // Counter value at which the product is complete and the counter saturates
    localparam logic [MUL_SW-1:0] MUL_DONE = 6'(MUL_STEPS);
    // Step in which the multiplier's sign bit is weighted negatively (signed mode)
    localparam logic [MUL_SW-1:0] MUL_LAST = 6'(MUL_STEPS - 1);
endpackage

// File: rtl/multiplier_mul_step.sv
// rtl/multiplier_mul_step.sv - one combinational shift-add partial-product step
module mul_step
    import multiplier_pkg::*;
(
    input  logic [2*MUL_W-1:0] w,
    input  logic [MUL_W-1:0]   y,
    input  logic               u,
    input  logic               last,
    output logic [2*MUL_W-1:0] p_next
);
    logic           b;
    logic [MUL_W:0] hx;
    logic [MUL_W:0] yx;
    logic [MUL_W:0] s;

    // Extend the high half and the multiplier to 33 bits, then add or subtract.
    // The final signed step subtracts so bit 31 of x carries negative weight.
    always_comb begin
        b  = w[0];
        hx = u ? {1'b0, w[2*MUL_W-1:MUL_W]} : {w[2*MUL_W-1], w[2*MUL_W-1:MUL_W]};
        yx = u ? {1'b0, y} : {y[MUL_W-1], y};
        if (!u && b && last) begin
            s = hx - yx;
        end else begin
            s = hx + (b ? yx : '0);
        end
        p_next = {s, w[MUL_W-1:1]};
    end
endmodule

// File: rtl/multiplier.sv
// rtl/multiplier.sv - sequential 32x32->64 signed/unsigned multiplier with run/stall handshake
module multiplier
    import multiplier_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               u,
    input  logic [MUL_W-1:0]   x,
    input  logic [MUL_W-1:0]   y,
    output logic               stall,
    output logic [2*MUL_W-1:0] z
);
    logic [MUL_SW-1:0]  s_cnt;
    logic [2*MUL_W-1:0] p;
    logic [2*MUL_W-1:0] w;
    logic [2*MUL_W-1:0] p_next;
    logic               last;

    // First step takes the multiplicand directly, so a stale P never leaks into a new operation
    always_comb begin
        w     = (s_cnt == '0) ? {{MUL_W{1'b0}}, x} : p;
        last  = (s_cnt == MUL_LAST);
        stall = run && (s_cnt != MUL_DONE);
        z     = p;
    end

    mul_step u_step (
        .w      (w),
        .y      (y),
        .u      (u),
        .last   (last),
        .p_next (p_next)
    );

    // Step counter and product register; both freeze once the counter saturates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_cnt <= '0;
            p     <= '0;
        end else if (!run) begin
            s_cnt <= '0;
        end else if (s_cnt != MUL_DONE) begin
            s_cnt <= s_cnt + 1'b1;
            p     <= p_next;
        end
    end
endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - directed self-checking bench for the sequential multiplier
module tb_multiplier;
    logic        clk;
    logic        rst;
    logic        run;
    logic        u;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [63:0] z;

    int n_checks;
    int n_errors;

    multiplier dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .u     (u),
        .x     (x),
        .y     (y),
        .stall (stall),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Count stall-high cycles (bounded) from the current cycle, then check width and product
    task automatic wait_done(input string tag, input logic [63:0] exp);
        int n;
        n = 0;
        #1;
        while (stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall_width"}, 64'(n), 64'd32);
        check({tag, "_z"}, z, exp);
    endtask

    // Called just after a negedge with run low; leaves run high at completion
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic uu, input logic [63:0] exp);
        x   = a;
        y   = b;
        u   = uu;
        run = 1'b1;
        wait_done(tag, exp);
    endtask

    task automatic idle_cycle();
        run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ru;
        logic [63:0] ref_p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        run = 1'b0;
        u   = 1'b1;
        x   = '0;
        y   = '0;

        // Reset state
        #2;
        check("reset_z", z, 64'd0);
        check("reset_stall_run0", 64'(stall), 64'd0);
        run = 1'b1;
        #1;
        check("reset_stall_run1", 64'(stall), 64'd1);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        idle_cycle();
        do_op("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
        idle_cycle();
        do_op("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001);
        idle_cycle();
        do_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        idle_cycle();
        do_op("s_7xm3", 32'd7, 32'hFFFF_FFFD, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
        idle_cycle();

        // Hold run past completion: result must stay put
        do_op("hold", 32'd6, 32'd7, 1'b1, 64'd42);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("hold_stall", 64'(stall), 64'd0);
            check("hold_z", z, 64'd42);
        end
        idle_cycle();
        do_op("rerun", 32'd5, 32'd5, 1'b1, 64'd25);
        idle_cycle();

        // Abort at S = 5, then restart with new operands
        x   = 32'hDEAD_BEEF;
        y   = 32'h0BAD_F00D;
        u   = 1'b1;
        run = 1'b1;
        repeat (5) @(negedge clk);
        idle_cycle();
        do_op("abort_restart", 32'h1234_5678, 32'h10, 1'b1, 64'h0000_0001_2345_6780);
        idle_cycle();

        // Asynchronous reset at S = 10, then restart with run still high
        x   = 32'd1000;
        y   = 32'd3;
        u   = 1'b1;
        run = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_z", z, 64'd0);
        check("rst_mid_stall", 64'(stall), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        wait_done("rst_restart", 64'd3000);
        idle_cycle();

        // Small randomized sweep against a reference product
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            ru = 1'($urandom_range(0, 1));
            if (i == 0) ra = 32'h0;
            if (i == 1) rb = 32'h8000_0000;
            if (ru) begin
                ref_p = {32'b0, ra} * {32'b0, rb};
            end else begin
                sa    = {{32{ra[31]}}, ra};
                sb    = {{32{rb[31]}}, rb};
                ref_p = sa * sb;
            end
            do_op("rand", ra, rb, ru, ref_p);
            idle_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
